// File: rtl/bram_mask_arbiter.sv
// Two-port round-robin front end for a single-port masked BRAM: zero-fills the array
// after reset, expands byte enables to bit masks, and supports locked (atomic) sequences.
module bram_mask_arbiter #(
  parameter  int MEMORY_SIZE = 8,
  parameter  int XLEN        = 16,
  localparam int BE          = XLEN / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  output logic                   init_done_o,

  input  logic                   a_req_i,
  input  logic                   a_we_i,
  input  logic                   a_lock_i,
  input  logic [MEMORY_SIZE-1:0] a_addr_i,
  input  logic [XLEN-1:0]        a_wdata_i,
  input  logic [BE-1:0]          a_be_i,
  output logic                   a_gnt_o,
  output logic                   a_rvalid_o,
  output logic [XLEN-1:0]        a_rdata_o,

  input  logic                   b_req_i,
  input  logic                   b_we_i,
  input  logic                   b_lock_i,
  input  logic [MEMORY_SIZE-1:0] b_addr_i,
  input  logic [XLEN-1:0]        b_wdata_i,
  input  logic [BE-1:0]          b_be_i,
  output logic                   b_gnt_o,
  output logic                   b_rvalid_o,
  output logic [XLEN-1:0]        b_rdata_o,

  output logic                   mem_write_o,
  output logic [MEMORY_SIZE-1:0] mem_addr_o,
  output logic [XLEN-1:0]        mem_data_o,
  output logic [XLEN-1:0]        mem_mask_o,
  input  logic [XLEN-1:0]        mem_data_i
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_ARB,
    ST_LOCK_A,
    ST_LOCK_B
  } state_e;

  typedef enum logic {
    RR_A,
    RR_B
  } rr_e;

  localparam logic [MEMORY_SIZE-1:0] CLR_LAST = '1;

  state_e                   state_q, state_d;
  rr_e                      rr_q, rr_d;
  logic [MEMORY_SIZE-1:0]   clr_cnt_q, clr_cnt_d;
  logic                     init_done_q, init_done_d;
  logic                     gnt_a, gnt_b;
  logic                     a_rvalid_q, b_rvalid_q;
  logic [XLEN-1:0]          a_rdata_q, b_rdata_q;

  function automatic logic [XLEN-1:0] expand_be(input logic [BE-1:0] be);
    logic [XLEN-1:0] m;
    m = '0;
    for (int k = 0; k < BE; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

  // Next-state, arbitration and grant logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d     = state_q;
    rr_d        = rr_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d     = ST_ARB;
          init_done_d = 1'b1;
        end
      end

      ST_ARB: begin
        if (a_req_i && (!b_req_i || rr_q == RR_A)) begin
          gnt_a = 1'b1;
          rr_d  = RR_B;
          if (a_lock_i) state_d = ST_LOCK_A;
        end else if (b_req_i) begin
          gnt_b = 1'b1;
          rr_d  = RR_A;
          if (b_lock_i) state_d = ST_LOCK_B;
        end
      end

      // Locked: only the owner is served; the pointer moves only on the releasing access.
      ST_LOCK_A: begin
        if (a_req_i) begin
          gnt_a = 1'b1;
          if (!a_lock_i) begin
            state_d = ST_ARB;
            rr_d    = RR_B;
          end
        end
      end

      ST_LOCK_B: begin
        if (b_req_i) begin
          gnt_b = 1'b1;
          if (!b_lock_i) begin
            state_d = ST_ARB;
            rr_d    = RR_A;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // Memory-side mux: zero-fill while clearing, otherwise the granted port.
  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_mask_o  = '0;
    if (state_q == ST_CLEAR) begin
      mem_write_o = 1'b1;
      mem_addr_o  = clr_cnt_q;
      mem_mask_o  = '1;
    end else if (gnt_a) begin
      mem_write_o = a_we_i;
      mem_addr_o  = a_addr_i;
      mem_data_o  = a_wdata_i;
      mem_mask_o  = a_we_i ? expand_be(a_be_i) : '0;
    end else if (gnt_b) begin
      mem_write_o = b_we_i;
      mem_addr_o  = b_addr_i;
      mem_data_o  = b_wdata_i;
      mem_mask_o  = b_we_i ? expand_be(b_be_i) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_CLEAR;
      rr_q        <= RR_A;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      rr_q        <= rr_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      a_rvalid_q  <= gnt_a && !a_we_i;
      b_rvalid_q  <= gnt_b && !b_we_i;
      if (gnt_a && !a_we_i) a_rdata_q <= mem_data_i;
      if (gnt_b && !b_we_i) b_rdata_q <= mem_data_i;
    end
  end

  assign init_done_o = init_done_q;
  assign a_gnt_o     = gnt_a;
  assign b_gnt_o     = gnt_b;
  assign a_rvalid_o  = a_rvalid_q;
  assign b_rvalid_o  = b_rvalid_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;

endmodule

// File: tb/tb_bram_mask_arbiter.sv
// Directed bench for bram_mask_arbiter with a behavioural masked BRAM and a
// read-data scoreboard fed from a reference copy of the memory contents.
module tb_bram_mask_arbiter;

  localparam int MS    = 4;
  localparam int XL    = 16;
  localparam int NB    = XL / 8;
  localparam int DEPTH = 2 ** MS;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          init_done_o;
  logic          a_req_i, a_we_i, a_lock_i;
  logic [MS-1:0] a_addr_i;
  logic [XL-1:0] a_wdata_i;
  logic [NB-1:0] a_be_i;
  logic          a_gnt_o, a_rvalid_o;
  logic [XL-1:0] a_rdata_o;
  logic          b_req_i, b_we_i, b_lock_i;
  logic [MS-1:0] b_addr_i;
  logic [XL-1:0] b_wdata_i;
  logic [NB-1:0] b_be_i;
  logic          b_gnt_o, b_rvalid_o;
  logic [XL-1:0] b_rdata_o;
  logic          mem_write_o;
  logic [MS-1:0] mem_addr_o;
  logic [XL-1:0] mem_data_o, mem_mask_o, mem_data_i;

  always #5 clk_i = ~clk_i;

  bram_mask_arbiter #(.MEMORY_SIZE(MS), .XLEN(XL)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .init_done_o(init_done_o),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_lock_i(a_lock_i), .a_addr_i(a_addr_i),
    .a_wdata_i(a_wdata_i), .a_be_i(a_be_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_lock_i(b_lock_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_be_i(b_be_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o),
    .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i)
  );

  // Behavioural bram_mask: asynchronous read, masked synchronous write, powers up dirty.
  logic [XL-1:0] bram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) bram[i] = 16'hDEAD;
  always @(posedge clk_i) begin
    if (mem_write_o) bram[mem_addr_o] <= (bram[mem_addr_o] & ~mem_mask_o) | (mem_data_o & mem_mask_o);
  end
  assign mem_data_i = bram[mem_addr_o];

  logic [XL-1:0] ref_mem [DEPTH];
  logic [XL-1:0] a_q[$], b_q[$];
  bit            a_due, b_due;
  int            n_cmp = 0;
  int            n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, we, lock, input logic [MS-1:0] addr,
                       input logic [XL-1:0] wdata, input logic [NB-1:0] be);
    a_req_i = req; a_we_i = we; a_lock_i = lock; a_addr_i = addr; a_wdata_i = wdata; a_be_i = be;
  endtask

  task automatic set_b(input logic req, we, lock, input logic [MS-1:0] addr,
                       input logic [XL-1:0] wdata, input logic [NB-1:0] be);
    b_req_i = req; b_we_i = we; b_lock_i = lock; b_addr_i = addr; b_wdata_i = wdata; b_be_i = be;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Called at the falling edge: retire read responses due from the previous grant.
  task automatic sample();
    check("a_rvalid", a_rvalid_o, a_due);
    check("b_rvalid", b_rvalid_o, b_due);
    if (a_due) check("a_rdata", a_rdata_o, a_q.pop_front());
    if (b_due) check("b_rdata", b_rdata_o, b_q.pop_front());
    a_due = 1'b0;
    b_due = 1'b0;
  endtask

  task automatic grant_effect(input bit is_b);
    logic          we;
    logic [MS-1:0] addr;
    logic [XL-1:0] wdata, m;
    logic [NB-1:0] be;
    we    = is_b ? b_we_i    : a_we_i;
    addr  = is_b ? b_addr_i  : a_addr_i;
    wdata = is_b ? b_wdata_i : a_wdata_i;
    be    = is_b ? b_be_i    : a_be_i;
    m     = {{8{be[1]}}, {8{be[0]}}};
    check("mem_addr", mem_addr_o, addr);
    check("mem_write", mem_write_o, we);
    if (we) begin
      check("mem_mask_wr", mem_mask_o, m);
      check("mem_data_wr", mem_data_o, wdata);
      ref_mem[addr] = (ref_mem[addr] & ~m) | (wdata & m);
    end else begin
      check("mem_mask_rd", mem_mask_o, 0);
      if (is_b) begin b_q.push_back(ref_mem[addr]); b_due = 1'b1; end
      else      begin a_q.push_back(ref_mem[addr]); a_due = 1'b1; end
    end
  endtask

  task automatic cycle(input bit ga, input bit gb);
    @(negedge clk_i);
    sample();
    check("init_done", init_done_o, 1);
    check("a_gnt", a_gnt_o, ga);
    check("b_gnt", b_gnt_o, gb);
    if (ga)      grant_effect(1'b0);
    else if (gb) grant_effect(1'b1);
    else         check("mem_write_idle", mem_write_o, 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      sample();
      check("clr_write", mem_write_o, 1);
      check("clr_addr", mem_addr_o, i);
      check("clr_mask", mem_mask_o, 16'hFFFF);
      check("clr_data", mem_data_o, 0);
      check("clr_init_done", init_done_o, 0);
      check("clr_a_gnt", a_gnt_o, 0);
      check("clr_b_gnt", b_gnt_o, 0);
      @(posedge clk_i);
      #1;
    end
  endtask

  // Asserts reset between edges and checks that outputs respond without a clock.
  task automatic reset_pulse();
    rst_n_i = 1'b0;
    #2;
    check("rst_init_done", init_done_o, 0);
    check("rst_a_gnt", a_gnt_o, 0);
    check("rst_b_gnt", b_gnt_o, 0);
    check("rst_a_rvalid", a_rvalid_o, 0);
    check("rst_b_rvalid", b_rvalid_o, 0);
    check("rst_a_rdata", a_rdata_o, 0);
    check("rst_b_rdata", b_rdata_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    a_q.delete();
    b_q.delete();
    a_due = 1'b0;
    b_due = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    clear_ref();
    set_a(0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0);
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Zero-fill with A already requesting, then read every word back.
    set_a(1, 0, 0, 0, 0, 0);
    reset_pulse();
    clear_phase(DEPTH);
    clear_ref();
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1, 0, 0, i[MS-1:0], 0, 0);
      cycle(1, 0);
    end
    set_a(0, 0, 0, 0, 0, 0);
    cycle(0, 0);

    // Byte-masked writes then read on A.
    set_a(1, 1, 0, 3, 16'hBEEF, 2'b11); cycle(1, 0);
    set_a(1, 1, 0, 3, 16'h1234, 2'b01); cycle(1, 0);
    set_a(1, 0, 0, 3, 0, 0);            cycle(1, 0);
    set_a(0, 0, 0, 0, 0, 0);            cycle(0, 0);
    check("t2_rdata", a_rdata_o, 16'hBE34);
    cycle(0, 0);
    check("t2_rdata_hold", a_rdata_o, 16'hBE34);

    // Lone B read leaves the pointer at A, then contend for six cycles.
    set_b(1, 0, 0, 3, 0, 0); cycle(0, 1);
    set_a(1, 0, 0, 1, 0, 0);
    set_b(1, 0, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0);
      cycle(0, 1);
    end

    // A holds a lock across three accesses plus an idle cycle; B starves until release.
    set_b(1, 0, 0, 5, 0, 0);
    set_a(1, 1, 1, 5, 16'h1111, 2'b11); cycle(1, 0);
    set_a(1, 1, 1, 5, 16'h2222, 2'b11); cycle(1, 0);
    set_a(0, 0, 1, 5, 0, 0);            cycle(0, 0);
    set_a(1, 1, 1, 5, 16'h3333, 2'b10); cycle(1, 0);
    set_a(1, 1, 0, 5, 16'h4444, 2'b01); cycle(1, 0);
    set_a(1, 0, 0, 6, 0, 0);            cycle(0, 1);
    set_a(0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0);            cycle(0, 0);
    check("t4_b_rdata", b_rdata_o, 16'h3344);

    // Read-after-write across ports, then a be=0 write that must not change memory.
    set_b(1, 1, 0, 7, 16'h00FF, 2'b11); cycle(0, 1);
    set_b(0, 0, 0, 0, 0, 0);
    set_a(1, 0, 0, 7, 0, 0);            cycle(1, 0);
    set_a(0, 0, 0, 0, 0, 0);            cycle(0, 0);
    check("t6_a_rdata", a_rdata_o, 16'h00FF);
    set_a(1, 1, 0, 7, 16'hFFFF, 2'b00); cycle(1, 0);
    set_a(1, 0, 0, 7, 0, 0);            cycle(1, 0);
    set_a(0, 0, 0, 0, 0, 0);            cycle(0, 0);
    check("be0_a_rdata", a_rdata_o, 16'h00FF);

    // Reset during LOCK_B, then again part-way through the zero-fill.
    set_b(1, 0, 1, 7, 0, 0); cycle(0, 1);
    set_b(0, 0, 0, 0, 0, 0);
    set_a(1, 0, 0, 7, 0, 0);
    cycle(0, 0);
    cycle(0, 0);
    reset_pulse();
    clear_phase(5);
    reset_pulse();
    clear_phase(DEPTH);
    clear_ref();
    set_b(1, 0, 0, 2, 0, 0);
    cycle(1, 0);
    cycle(0, 1);
    set_a(0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0);
    cycle(0, 0);
    check("t5_a_rdata", a_rdata_o, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
